// File: rtl/nubus_memory_ws.sv
// nubus_memory_ws
//   Word-organised RAM model sitting behind the NuBus slave interface.
//   After reset it sweeps zeros into every word (mem_busy_o high). Then it
//   accepts one request at a time. Each request takes WAIT_CLOCKS wait
//   states before a single-cycle mem_ready_o pulse. Dropping mem_valid
//   during the wait states aborts the request.
//
//   Optional feature macro: NUBUS_MEM_ERR_EN
//     When it is defined, the block checks the address range. Out-of-range
//     requests complete with mem_error_o and have no side effects. When it
//     is undefined, upper address bits alias and an index >= DEPTH reads
//     zero and drops the write.
//
// Ports
//   mem_clk      in   clock, rising edge
//   mem_resetn   in   synchronous active-low reset
//   mem_valid    in   request, held until mem_ready_o or withdrawn to abort
//   mem_wstrb    in   byte write strobes, all zero = read
//   mem_addr     in   byte address, word index = mem_addr[AW+1:2]
//   mem_wdata    in   write data
//   mem_myslot   in   slot-space select
//   mem_myexp    in   expansion-space select
//   mem_rdata_o  out  registered read data, changes only on a completed read
//   mem_ready_o  out  one-cycle completion pulse
//   mem_write_o  out  accepted request is a write
//   mem_error_o  out  out-of-range completion, coincident with mem_ready_o
//   mem_busy_o   out  clear sweep in progress
module nubus_memory_ws #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CLOCKS = 0
) (
    input  logic                mem_clk,
    input  logic                mem_resetn,
    input  logic                mem_valid,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [31:0]         mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_myslot,
    input  logic                mem_myexp,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ready_o,
    output logic                mem_write_o,
    output logic                mem_error_o,
    output logic                mem_busy_o
);
    localparam int              NB       = DATA_W / 8;
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
`ifdef NUBUS_MEM_ERR_EN
    localparam bit              ERR_EN   = 1'b1;
`else
    localparam bit              ERR_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_t;

    state_t            state, next_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     clr_cnt, idx_q, in_idx, rd_idx;
    logic [3:0]        wait_cnt;
    logic [NB-1:0]     wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oor_q, in_oor, rd_oor, accept, load_rd;
    logic              unused_addr;

    assign in_idx      = mem_addr[AW+1:2];
    assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

`ifdef NUBUS_MEM_ERR_EN
    assign in_oor = ({1'b0, in_idx} >= DEPTH_V) || (mem_addr[31:AW+2] != '0);
`else
    assign in_oor = ({1'b0, in_idx} >= DEPTH_V);
`endif

    assign accept = (state == IDLE) && mem_valid && (mem_myslot || mem_myexp);

    // Read data is loaded on the edge that enters DONE, so it is already
    // valid while mem_ready_o is high. With no wait states, that edge is the
    // acceptance edge itself, so the live index is used instead of the
    // latched one.
    assign load_rd = (accept && (WAIT_CLOCKS == 0) && (mem_wstrb == '0)) ||
                     ((state == WAIT) && mem_valid && (wait_cnt == 4'd1) &&
                      (wstrb_q == '0));
    assign rd_idx  = (state == IDLE) ? in_idx : idx_q;
    assign rd_oor  = (state == IDLE) ? in_oor : oor_q;

    always_comb begin
        next_state  = state;
        mem_ready_o = 1'b0;
        mem_error_o = 1'b0;
        mem_busy_o  = 1'b0;
        case (state)
            CLEAR: begin
                mem_busy_o = 1'b1;
                if (clr_cnt == LAST_IDX) next_state = IDLE;
            end
            IDLE: begin
                if (accept) next_state = (WAIT_CLOCKS == 0) ? DONE : WAIT;
            end
            WAIT: begin
                if (!mem_valid)             next_state = IDLE;
                else if (wait_cnt == 4'd1)  next_state = DONE;
            end
            DONE: begin
                mem_ready_o = 1'b1;
                mem_error_o = ERR_EN && oor_q;
                next_state  = IDLE;
            end
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!mem_resetn) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            wait_cnt    <= '0;
            idx_q       <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            oor_q       <= 1'b0;
            mem_write_o <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR)
                clr_cnt <= (clr_cnt == LAST_IDX) ? '0 : clr_cnt + AW'(1);
            if (accept) begin
                idx_q       <= in_idx;
                wstrb_q     <= mem_wstrb;
                wdata_q     <= mem_wdata;
                oor_q       <= in_oor;
                mem_write_o <= |mem_wstrb;
                wait_cnt    <= 4'(WAIT_CLOCKS);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (load_rd) begin
                if (!rd_oor)
                    mem_rdata_o <= mem[rd_idx];
                else if (!ERR_EN)
                    mem_rdata_o <= '0;
            end
        end
    end

    // Array has no reset. Writes are gated by mem_resetn so that a write
    // pending in DONE is dropped when reset arrives in the same cycle.
    always_ff @(posedge mem_clk) begin
        if (mem_resetn) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if ((state == DONE) && !oor_q) begin
                for (int b = 0; b < NB; b++)
                    if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_nubus_memory_ws.sv
module tb_nubus_memory_ws;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 200;
    localparam int WAIT_CLOCKS = 3;
    localparam int LAT         = WAIT_CLOCKS + 1;
    localparam int SPACING     = WAIT_CLOCKS + 2;
`ifdef NUBUS_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              mem_clk = 1'b0;
    logic              mem_resetn = 1'b0;
    logic              mem_valid = 1'b0;
    logic [3:0]        mem_wstrb = '0;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic              mem_myslot = 1'b1;
    logic              mem_myexp = 1'b0;
    logic [31:0]       mem_rdata_o;
    logic              mem_ready_o, mem_write_o, mem_error_o, mem_busy_o;

    nubus_memory_ws #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CLOCKS(WAIT_CLOCKS)) dut (
        .mem_clk(mem_clk), .mem_resetn(mem_resetn), .mem_valid(mem_valid),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_myslot(mem_myslot), .mem_myexp(mem_myexp),
        .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
        .mem_write_o(mem_write_o), .mem_error_o(mem_error_o),
        .mem_busy_o(mem_busy_o)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] strb, input logic [31:0] rd, input logic err);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        e.wr    = |strb;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed unexpected ready expected empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " rdata"}, 64'(mem_rdata_o), 64'(e.rdata));
            chk({tag, " error"}, 64'(mem_error_o), 64'(e.err));
            chk({tag, " write"}, 64'(mem_write_o), 64'(e.wr));
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
        int lat = 0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = data;
        push_exp(strb, exp_rd, exp_err);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge mem_clk);
            if (mem_ready_o) lat = i;
            if (i == 1) begin
                // request data must have been latched at acceptance
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_wstrb = 4'($urandom);
            end
        end
        mem_valid = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
        if (lat != 0) pop_check(tag);
        else void'(sb.pop_back());
        if (strb == 4'b0) last_rd = exp_rd;
        @(negedge mem_clk);
    endtask

    task automatic abort_req(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] data);
        int rdy = 0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = data;
        @(negedge mem_clk);
        if (mem_ready_o) rdy++;
        @(negedge mem_clk);
        if (mem_ready_o) rdy++;
        mem_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge mem_clk);
            if (mem_ready_o) rdy++;
        end
        chk({tag, " ready count"}, 64'(rdy), 64'(0));
        chk({tag, " rdata held"}, 64'(mem_rdata_o), 64'(last_rd));
    endtask

    // Called at the negedge where mem_resetn has just been released.
    task automatic sweep(input string tag, input int hold);
        int cnt = 0;
        int rdy = 0;
        while (mem_busy_o && cnt < 1000) begin
            cnt++;
            if (mem_ready_o) rdy++;
            if (cnt == hold) mem_valid = 1'b0;
            @(negedge mem_clk);
        end
        mem_valid = 1'b0;
        chk({tag, " busy cycles"}, 64'(cnt), 64'(DEPTH));
        for (int i = 0; i < 4; i++) begin
            if (mem_ready_o) rdy++;
            @(negedge mem_clk);
        end
        chk({tag, " ready during sweep"}, 64'(rdy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t[3];
        int k;
        int rdy;

        // reset values, with a request asserted during reset (reset wins)
        mem_valid = 1'b1;
        mem_addr  = 32'h10;
        mem_wstrb = 4'b0;
        repeat (3) @(negedge mem_clk);
        chk("rst rdata", 64'(mem_rdata_o), 64'(0));
        chk("rst ready", 64'(mem_ready_o), 64'(0));
        chk("rst write", 64'(mem_write_o), 64'(0));
        chk("rst error", 64'(mem_error_o), 64'(0));
        chk("rst busy",  64'(mem_busy_o),  64'(1));

        // sweep with a read of 0x10 held for part of it
        mem_resetn = 1'b1;
        sweep("sweep0", 50);
        chk("post sweep busy", 64'(mem_busy_o), 64'(0));
        xfer("rd 0x10", 32'h10, 4'b0, 32'h0, 32'h0, 1'b0);
        xfer("rd last", 32'h31C, 4'b0, 32'h0, 32'h0, 1'b0);

        // byte strobes
        xfer("wr 0x40", 32'h40, 4'b0101, 32'hDEADBEEF, last_rd, 1'b0);
        xfer("rd 0x40", 32'h40, 4'b0, 32'h0, 32'h00AD00EF, 1'b0);
        mem_myslot = 1'b0;
        mem_myexp  = 1'b1;
        xfer("wr 0x44 exp", 32'h44, 4'b1111, 32'hCAFEF00D, last_rd, 1'b0);
        mem_myslot = 1'b1;
        mem_myexp  = 1'b0;
        xfer("wr 0x44 b3", 32'h44, 4'b1000, 32'h99000000, last_rd, 1'b0);
        xfer("rd 0x44", 32'h44, 4'b0, 32'h0, 32'h99FEF00D, 1'b0);

        // no space select: ignored
        mem_myslot = 1'b0;
        mem_valid  = 1'b1;
        mem_addr   = 32'h40;
        mem_wstrb  = 4'b0;
        rdy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge mem_clk);
            if (mem_ready_o) rdy++;
        end
        mem_valid  = 1'b0;
        mem_myslot = 1'b1;
        chk("unselected ready count", 64'(rdy), 64'(0));
        @(negedge mem_clk);

        // aborts
        abort_req("abort rd", 32'h40, 4'b0, 32'h0);
        abort_req("abort wr", 32'h40, 4'b1111, 32'h11223344);
        xfer("rd 0x40 after abort", 32'h40, 4'b0, 32'h0, 32'h00AD00EF, 1'b0);

        // back-to-back with mem_valid held
        mem_valid = 1'b1;
        mem_addr  = 32'h40;
        mem_wstrb = 4'b0;
        push_exp(4'b0, 32'h00AD00EF, 1'b0);
        push_exp(4'b0, 32'h99FEF00D, 1'b0);
        push_exp(4'b0, 32'h00AD00EF, 1'b0);
        k = 0;
        for (int i = 1; i <= 40 && k < 3; i++) begin
            @(negedge mem_clk);
            if (mem_ready_o) begin
                t[k] = i;
                pop_check("b2b");
                k++;
                if (k == 1) mem_addr = 32'h44;
                if (k == 2) mem_addr = 32'h40;
                if (k == 3) mem_valid = 1'b0;
            end
        end
        mem_valid = 1'b0;
        chk("b2b count", 64'(k), 64'(3));
        if (k == 3) begin
            chk("b2b first latency", 64'(t[0]), 64'(LAT));
            chk("b2b spacing 1", 64'(t[1] - t[0]), 64'(SPACING));
            chk("b2b spacing 2", 64'(t[2] - t[1]), 64'(SPACING));
        end
        while (sb.size() > 0) void'(sb.pop_front());
        last_rd = 32'h00AD00EF;
        @(negedge mem_clk);

        // out of range / aliasing
        xfer("wr oor", 32'h320, 4'b1111, 32'hFFFFFFFF, last_rd, ERR_EN);
        if (ERR_EN) xfer("rd oor", 32'h320, 4'b0, 32'h0, last_rd, 1'b1);
        else        xfer("rd oor", 32'h320, 4'b0, 32'h0, 32'h0, 1'b0);
        if (ERR_EN) xfer("rd alias", 32'h1040, 4'b0, 32'h0, last_rd, 1'b1);
        else        xfer("rd alias", 32'h1040, 4'b0, 32'h0, 32'h00AD00EF, 1'b0);
        xfer("rd word0", 32'h0, 4'b0, 32'h0, 32'h0, 1'b0);
        xfer("rd 0x40 after oor", 32'h40, 4'b0, 32'h0, 32'h00AD00EF, 1'b0);

        // reset during WAIT of a write
        mem_valid = 1'b1;
        mem_addr  = 32'h08;
        mem_wstrb = 4'b1111;
        mem_wdata = 32'h12345678;
        @(negedge mem_clk);
        @(negedge mem_clk);
        chk("mid rst pre ready", 64'(mem_ready_o), 64'(0));
        mem_resetn = 1'b0;
        @(negedge mem_clk);
        chk("mid rst ready", 64'(mem_ready_o), 64'(0));
        chk("mid rst busy",  64'(mem_busy_o),  64'(1));
        chk("mid rst rdata", 64'(mem_rdata_o), 64'(0));
        chk("mid rst write", 64'(mem_write_o), 64'(0));
        last_rd    = '0;
        mem_resetn = 1'b1;
        mem_valid  = 1'b0;
        sweep("sweep1", 0);
        xfer("rd 0x08 after rst", 32'h08, 4'b0, 32'h0, 32'h0, 1'b0);
        xfer("rd 0x40 after rst", 32'h40, 4'b0, 32'h0, 32'h0, 1'b0);

        chk("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nubus_memory_ws.md
# nubus_memory_ws

Parametrised NuBus-side memory model: a word-organised RAM with byte strobes, a programmable wait-state counter, a post-reset clear sweep and abort on request withdrawal. Instantiated behind the NuBus slave interface in place of the fixed-width memory model. It generalises data width, depth and wait states, and adds optional range checking with an error response.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, range 8..64
- DEPTH, 256, number of words; any value 2..65536, need not be a power of two
- WAIT_CLOCKS, 0, wait states inserted before ready; range 0..15
- AW (localparam), $clog2(DEPTH), word-index width
- mem_clk  in  1  clock; all state changes on the rising edge
- mem_resetn  in  1  synchronous, active-low reset, sampled on the rising edge of mem_clk
- mem_valid  in  1  request; held by the master until mem_ready_o, or withdrawn to abort
- mem_wstrb  in  DATA_W/8  byte write strobes; all zero = read
- mem_addr  in  32  byte address; word index = mem_addr[AW+1:2], bits [1:0] ignored
- mem_wdata  in  DATA_W  write data
- mem_myslot  in  1  slot-space select
- mem_myexp  in  1  expansion-space select
- mem_rdata_o  out  DATA_W  registered read data
- mem_ready_o  out  1  one-cycle completion pulse
- mem_write_o  out  1  registered: accepted request is a write
- mem_error_o  out  1  one-cycle error pulse, coincident with mem_ready_o
- mem_busy_o  out  1  clear sweep in progress; requests are not accepted

## Operation
- FSM states: CLEAR, IDLE, WAIT, DONE.
- CLEAR: entered on reset. A counter writes zero to word 0..DEPTH-1, one word per cycle. Exactly DEPTH cycles, then IDLE. mem_busy_o=1 throughout CLEAR.
- IDLE: a request is accepted when mem_valid & (mem_myslot | mem_myexp). On acceptance, mem_addr, mem_wstrb and mem_wdata are latched, and mem_write_o <= |mem_wstrb. The FSM then enters WAIT with counter = WAIT_CLOCKS, or enters DONE directly if WAIT_CLOCKS=0.
- WAIT: the counter decrements each cycle; at 0 the FSM enters DONE. If mem_valid=0 in any WAIT cycle, the request aborts: IDLE next, no write, no ready, rdata unchanged.
- DONE: mem_ready_o=1 for this single cycle. A write commits on the closing edge, only for bytes whose latched strobe is 1. A read loads mem_rdata_o from the latched index, and the value is visible in the DONE cycle, so rdata is registered one cycle ahead from the array. Next state is IDLE. Latched request data is used, so input changes after acceptance are ignored.
- Back-to-back: if mem_valid is still high in the cycle after DONE, it is a new request and is accepted from IDLE.
- mem_rdata_o holds its value across writes and aborts; it changes only on a completed read.
- Out-of-range default: index >= DEPTH reads zero and drops the write. Address bits above AW+1 are ignored, so addresses alias.

## Timing
- Reset values: mem_rdata_o=0, mem_ready_o=0, mem_write_o=0, mem_error_o=0, mem_busy_o=1. FSM=CLEAR, clear counter=0.
- Access latency: mem_ready_o asserts WAIT_CLOCKS+1 cycles after the acceptance edge. Minimum request spacing is WAIT_CLOCKS+2 cycles.
- Reset mid-operation: the FSM returns to CLEAR, any pending write is dropped and the sweep restarts from word 0. Reset mid-sweep also restarts from word 0.
- Reset and valid asserted together: reset wins.
- mem_valid asserted during CLEAR is ignored and is not queued.

## Configuration
- NUBUS_MEM_ERR_EN defined: range checking is enabled. A request is out of range if mem_addr[31:AW+2] != 0 or the index is >= DEPTH. An out-of-range request completes with the normal latency, with mem_ready_o=1 and mem_error_o=1 in DONE. There is no write, and mem_rdata_o is unchanged.
- NUBUS_MEM_ERR_EN undefined: mem_error_o is tied to 0, and out-of-range requests take the default aliasing behaviour.

## Test plan
- Reset release, DEPTH=256: mem_busy_o=1 for exactly 256 cycles. A read of word 0x10 issued during the sweep is not acknowledged. The same read after the sweep returns 0.
- WAIT_CLOCKS=3, write 0xDEADBEEF to 0x40 with wstrb=4'b0101, then read 0x40: each mem_ready_o arrives 4 cycles after acceptance, and the read returns 0x00AD00EF.
- Read 0x40 issued, mem_valid dropped in the second WAIT cycle, then write 0x11223344 issued and aborted the same way: no mem_ready_o for either. A subsequent read of 0x40 returns its prior value.
- WAIT_CLOCKS=0, mem_valid held high over 3 requests: one mem_ready_o every 2 cycles.
- NUBUS_MEM_ERR_EN, DEPTH=200, write to byte address 0x320 (index 200): mem_ready_o and mem_error_o are both 1 in the same cycle, and no array word changes. Without the macro, the same write is dropped with mem_error_o=0.
- Reset pulsed during the WAIT cycle of a write to 0x08: no ready, the sweep restarts, and word 0x08 reads 0 afterwards.
